// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: multiplier FSM states, the mul ALU opcode
// and the default operand width.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   localparam logic [2:0] ALUOP_MUL = 3'b001;
   localparam int         MUL_WIDTH = 32;

endpackage

// File: rtl/mul_sequencer_if.sv
// EX-stage handshake between the pipeline (master) and the multi-cycle
// multiplier (slave).
import mips_pkg::*;

interface mul_sequencer_if #(
   parameter int WIDTH = MUL_WIDTH
);
   logic                 Start;
   logic                 Double;
   logic [WIDTH-1:0]     OperandA;
   logic [WIDTH-1:0]     OperandB;
   logic [4:0]           DestReg;
   logic                 Flush;
   logic                 Stall;
   logic                 Busy;
   logic                 Done;
   logic [2*WIDTH-1:0]   Result;
   logic [4:0]           ResultDest;
   logic                 ResultDouble;

   modport master (
      output Start, Double, OperandA, OperandB, DestReg, Flush,
      input  Stall, Busy, Done, Result, ResultDest, ResultDouble
   );

   modport slave (
      input  Start, Double, OperandA, OperandB, DestReg, Flush,
      output Stall, Busy, Done, Result, ResultDest, ResultDouble
   );
endinterface

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: one multiplier bit per step.
// MUL_EARLY_TERM_EN ends the run once no set multiplier bits remain.
import mips_pkg::*;

module mul_shift_add_dp #(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 load,
   input  logic                 step,
   input  logic [WIDTH-1:0]     operand_a,
   input  logic [WIDTH-1:0]     operand_b,
   output logic                 last,
   output logic [2*WIDTH-1:0]   product
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [CW-1:0]      count_reg;
   logic [2*WIDTH-1:0] acc_next;

   // product is the accumulator after the current step, so the sequencer can
   // register it on the very edge that leaves BUSY.
   assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
   assign product  = acc_next;

`ifdef MUL_EARLY_TERM_EN
   assign last = (count_reg == CW'(WIDTH - 1)) || ((mplier_reg >> 1) == '0);
`else
   assign last = (count_reg == CW'(WIDTH - 1));
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         count_reg  <= '0;
      end else if (load) begin
         mcand_reg  <= {{WIDTH{1'b0}}, operand_a};
         mplier_reg <= operand_b;
         acc_reg    <= '0;
         count_reg  <= '0;
      end else if (step) begin
         acc_reg    <= acc_next;
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         count_reg  <= count_reg + 1'b1;
      end
   end
endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply sequencer: holds the pipeline with Stall while the
// shift-add datapath runs, then pulses Done with the product registered.
// Optional early termination: define MUL_EARLY_TERM_EN.
import mips_pkg::*;

module mul_sequencer #(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic              Clk,
   input  logic              Rst,
   mul_sequencer_if.slave    bus
);
   mul_state_t          state_reg;
   logic                busy_reg;
   logic                done_reg;
   logic [2*WIDTH-1:0]  result_reg;
   logic [4:0]          result_dest_reg;
   logic                result_double_reg;
   logic [4:0]          dest_lat_reg;
   logic                double_lat_reg;

   logic                accept;
   logic                dp_step;
   logic                dp_last;
   logic [2*WIDTH-1:0]  dp_product;

   assign accept  = (state_reg == IDLE) && bus.Start && !bus.Flush;
   assign dp_step = (state_reg == BUSY);

   mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
      .Clk       (Clk),
      .Rst       (Rst),
      .load      (accept),
      .step      (dp_step),
      .operand_a (bus.OperandA),
      .operand_b (bus.OperandB),
      .last      (dp_last),
      .product   (dp_product)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_reg         <= IDLE;
         busy_reg          <= 1'b0;
         done_reg          <= 1'b0;
         result_reg        <= '0;
         result_dest_reg   <= '0;
         result_double_reg <= 1'b0;
         dest_lat_reg      <= '0;
         double_lat_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (accept) begin
                  state_reg      <= BUSY;
                  busy_reg       <= 1'b1;
                  dest_lat_reg   <= bus.DestReg;
                  double_lat_reg <= bus.Double;
               end
            end
            BUSY: begin
               // Flush wins over completion: an aborted op never reports.
               if (bus.Flush) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else if (dp_last) begin
                  state_reg         <= DONE;
                  busy_reg          <= 1'b0;
                  done_reg          <= 1'b1;
                  result_reg        <= double_lat_reg ? dp_product
                                       : {{WIDTH{1'b0}}, dp_product[WIDTH-1:0]};
                  result_dest_reg   <= dest_lat_reg;
                  result_double_reg <= double_lat_reg;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               done_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Combinational so the pipeline freezes in the Start cycle itself.
   assign bus.Stall        = accept || (state_reg == BUSY);
   assign bus.Busy         = busy_reg;
   assign bus.Done         = done_reg;
   assign bus.Result       = result_reg;
   assign bus.ResultDest   = result_dest_reg;
   assign bus.ResultDouble = result_double_reg;
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: vector table plus flush, reset and
// held-Start sequences. Latency expectations follow MUL_EARLY_TERM_EN.
module tb_mul_sequencer;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   mul_sequencer_if #(.WIDTH(W)) bus ();

   mul_sequencer #(.WIDTH(W)) dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           dbl;
      logic [4:0]     dest;
      logic [2*W-1:0] exp;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int exp_busy(input logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
      int n;
      n = 1;
      for (int i = 0; i < W; i++)
         if (b[i]) n = i + 1;
      return n;
`else
      return W;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until Done is seen; counts cycles after the Start cycle and the
   // stall-high cycles before Done. Drops Start after the first edge unless held.
   task automatic wait_done(input bit hold_start, output int cyc, output int stall_cnt);
      cyc = 0;
      stall_cnt = 0;
      do begin
         tick();
         if (cyc == 0 && !hold_start) bus.Start = 1'b0;
         cyc++;
         if (!bus.Done && bus.Stall) stall_cnt++;
      end while (!bus.Done && cyc < 200);
   endtask

   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic dbl, input logic [4:0] dest, input logic [2*W-1:0] exp);
      int cyc, sc, l;
      l = exp_busy(b);
      bus.OperandA = a;
      bus.OperandB = b;
      bus.Double   = dbl;
      bus.DestReg  = dest;
      bus.Start    = 1'b1;
      #1;
      sc = 0;
      chk({name, " stall_start"}, 64'(bus.Stall), 64'd1);
      wait_done(1'b0, cyc, sc);
      chk({name, " done_latency"}, 64'(cyc), 64'(l + 1));
      chk({name, " stall_cycles"}, 64'(sc + 1), 64'(l + 1));
      chk({name, " stall_in_done"}, 64'(bus.Stall), 64'd0);
      chk({name, " result"}, bus.Result, exp);
      chk({name, " dest"}, 64'(bus.ResultDest), 64'(dest));
      chk({name, " rdouble"}, 64'(bus.ResultDouble), 64'(dbl));
      tick();
      chk({name, " done_pulse"}, 64'(bus.Done), 64'd0);
   endtask

   initial begin
      int cyc, sc, dones;
      logic [2*W-1:0] prev;

      vecs[0]  = '{32'd3, 32'd5, 1'b0, 5'd7, 64'd15};
      vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd1, 64'hFFFFFFFE_00000001};
      vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd2, 64'h00000000_00000001};
      vecs[3]  = '{32'h10000, 32'h10000, 1'b1, 5'd3, 64'h1_00000000};
      vecs[4]  = '{32'h10000, 32'h10000, 1'b0, 5'd4, 64'h0};
      vecs[5]  = '{32'hFFFFFFFF, 32'd2, 1'b1, 5'd5, 64'h1_FFFFFFFE};
      vecs[6]  = '{32'hFFFFFFFF, 32'd2, 1'b0, 5'd6, 64'hFFFFFFFE};
      vecs[7]  = '{32'd1000, 32'd1000, 1'b0, 5'd8, 64'd1000000};
      vecs[8]  = '{32'd12345, 32'd4, 1'b1, 5'd9, 64'd49380};
      vecs[9]  = '{32'd7, 32'd0, 1'b1, 5'd31, 64'd0};
      vecs[10] = '{32'h80000000, 32'h80000000, 1'b1, 5'd10, 64'h40000000_00000000};

      bus.Start = 1'b0; bus.Double = 1'b0; bus.OperandA = '0; bus.OperandB = '0;
      bus.DestReg = '0; bus.Flush = 1'b0;

      repeat (3) tick();
      chk("reset busy", 64'(bus.Busy), 64'd0);
      chk("reset done", 64'(bus.Done), 64'd0);
      chk("reset stall", 64'(bus.Stall), 64'd0);
      chk("reset result", bus.Result, 64'd0);
      chk("reset dest", 64'(bus.ResultDest), 64'd0);
      chk("reset rdouble", 64'(bus.ResultDouble), 64'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 11; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].dbl, vecs[i].dest, vecs[i].exp);
         $display("vec%0d: %0h x %0h dbl=%0d -> %0h dest=%0d", i, vecs[i].a, vecs[i].b,
                  vecs[i].dbl, bus.Result, bus.ResultDest);
      end
      prev = vecs[10].exp;

      // Flush in the 10th BUSY cycle
      bus.OperandA = 32'd9; bus.OperandB = 32'hFFFFFFFF; bus.Double = 1'b1;
      bus.DestReg = 5'd20; bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      dones = 0;
      repeat (9) begin
         tick();
         if (bus.Done) dones++;
      end
      bus.Flush = 1'b1;
      tick();
      bus.Flush = 1'b0;
      chk("flush busy", 64'(bus.Busy), 64'd0);
      chk("flush stall", 64'(bus.Stall), 64'd0);
      repeat (40) begin
         if (bus.Done) dones++;
         tick();
      end
      chk("flush no_done", 64'(dones), 64'd0);
      chk("flush result", bus.Result, prev);
      chk("flush dest", 64'(bus.ResultDest), 64'd10);
      $display("flush: result=%0h dones=%0d", bus.Result, dones);

      // Reset in the 5th BUSY cycle
      bus.OperandA = 32'd9; bus.OperandB = 32'hFFFFFFFF; bus.Double = 1'b1;
      bus.DestReg = 5'd21; bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst busy", 64'(bus.Busy), 64'd0);
      chk("midrst stall", 64'(bus.Stall), 64'd0);
      chk("midrst done", 64'(bus.Done), 64'd0);
      chk("midrst result", bus.Result, 64'd0);
      chk("midrst dest", 64'(bus.ResultDest), 64'd0);
      chk("midrst rdouble", 64'(bus.ResultDouble), 64'd0);
      $display("midrst: result=%0h busy=%0d", bus.Result, bus.Busy);
      run_op("post_rst", 32'd9, 32'd9, 1'b0, 5'd12, 64'd81);
      $display("post_rst: result=%0d dest=%0d", bus.Result, bus.ResultDest);

      // Start held through the op and its DONE cycle
      bus.OperandA = 32'd6; bus.OperandB = 32'd7; bus.Double = 1'b0;
      bus.DestReg = 5'd13; bus.Start = 1'b1;
      wait_done(1'b1, cyc, sc);
      chk("held latency", 64'(cyc), 64'(exp_busy(32'd7) + 1));
      chk("held stall_in_done", 64'(bus.Stall), 64'd0);
      chk("held result", bus.Result, 64'd42);
      bus.DestReg = 5'd14;
      tick();
      chk("held idle_stall", 64'(bus.Stall), 64'd1);
      chk("held idle_done", 64'(bus.Done), 64'd0);
      chk("held idle_busy", 64'(bus.Busy), 64'd0);
      tick();
      chk("held reaccept", 64'(bus.Busy), 64'd1);
      bus.Start = 1'b0;
      dones = 0;
      cyc = 0;
      while (!bus.Done && cyc < 200) begin
         tick();
         cyc++;
      end
      repeat (40) begin
         if (bus.Done) dones++;
         tick();
      end
      chk("held one_done", 64'(dones), 64'd1);
      chk("held dest2", 64'(bus.ResultDest), 64'd14);
      $display("held: result=%0d dest=%0d dones=%0d", bus.Result, bus.ResultDest, dones);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
